// File: rtl/machine_timer.sv
// CLINT-style machine timer: free-running 64-bit mtime, mtimecmp and msip behind a single-cycle bus port.
// Define MACHINE_TIMER_MSIP_EN to implement the msip flop; otherwise MSIP reads 0 and the software interrupt is tied low.
module machine_timer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0200_0000),
    parameter int                    PRESCALE   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  timer_interrupt_o,
    output logic                  software_interrupt_o
);

    localparam logic [ADDR_WIDTH-1:0] A_MSIP   = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] A_CMP_LO = BASE_ADDR + ADDR_WIDTH'(32'h0000_4000);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_HI = BASE_ADDR + ADDR_WIDTH'(32'h0000_4004);
    localparam logic [ADDR_WIDTH-1:0] A_TIM_LO = BASE_ADDR + ADDR_WIDTH'(32'h0000_BFF8);
    localparam logic [ADDR_WIDTH-1:0] A_TIM_HI = BASE_ADDR + ADDR_WIDTH'(32'h0000_BFFC);
    localparam logic [15:0]           PRE_MAX  = 16'(PRESCALE - 1);

    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [15:0]           r_presc;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_tick;
    logic                  w_sel_cmp_lo;
    logic                  w_sel_cmp_hi;
    logic                  w_sel_tim_lo;
    logic                  w_sel_tim_hi;
    logic [DATA_WIDTH-1:0] w_rmux;

    assign w_wr   = req_i & we_i;
    assign w_rd   = req_i & ~we_i;
    assign w_tick = (r_presc == PRE_MAX);

    // Exact address match also rejects misaligned accesses, since every mapped word is aligned.
    assign w_sel_cmp_lo = (addr_i == A_CMP_LO);
    assign w_sel_cmp_hi = (addr_i == A_CMP_HI);
    assign w_sel_tim_lo = (addr_i == A_TIM_LO);
    assign w_sel_tim_hi = (addr_i == A_TIM_HI);

`ifdef MACHINE_TIMER_MSIP_EN
    logic r_msip;
    logic w_sel_msip;

    assign w_sel_msip = (addr_i == A_MSIP);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_msip <= 1'b0;
        end else if (w_wr && w_sel_msip) begin
            r_msip <= wdata_i[0];
        end
    end

    assign software_interrupt_o = r_msip;
`else
    assign software_interrupt_o = 1'b0;
`endif

    always_comb begin
        w_rmux = '0;
        if (w_sel_cmp_lo) begin
            w_rmux = r_mtimecmp[31:0];
        end else if (w_sel_cmp_hi) begin
            w_rmux = r_mtimecmp[63:32];
        end else if (w_sel_tim_lo) begin
            w_rmux = r_mtime[31:0];
        end else if (w_sel_tim_hi) begin
            w_rmux = r_mtime[63:32];
`ifdef MACHINE_TIMER_MSIP_EN
        end else if (w_sel_msip) begin
            w_rmux = {{(DATA_WIDTH-1){1'b0}}, r_msip};
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_presc    <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
        end else begin
            r_ack   <= req_i;
            r_rdata <= w_rd ? w_rmux : '0;
            r_presc <= w_tick ? 16'd0 : 16'(r_presc + 16'd1);

            // A software write to either mtime half swallows this edge's increment.
            if (w_wr && w_sel_tim_lo) begin
                r_mtime[31:0] <= wdata_i;
            end else if (w_wr && w_sel_tim_hi) begin
                r_mtime[63:32] <= wdata_i;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr && w_sel_cmp_lo) begin
                r_mtimecmp[31:0] <= wdata_i;
            end
            if (w_wr && w_sel_cmp_hi) begin
                r_mtimecmp[63:32] <= wdata_i;
            end
        end
    end

    assign ack_o             = r_ack;
    assign rdata_o           = r_rdata;
    assign timer_interrupt_o = (r_mtime >= r_mtimecmp);

endmodule
